// File: rtl/v850_pkg.sv
// Shared types and the instruction-length rule for the V850 fetch/align slice.
package v850_pkg;

    typedef logic [15:0] hw_t;
    typedef logic [31:0] addr_t;

    localparam hw_t NOP_HW = 16'h0000;

    // Format V and up (32-bit) have bits [10:9] of the first halfword both set.
    function automatic logic is_len32(hw_t hw);
        return hw[10:9] == 2'b11;
    endfunction

endpackage

// File: rtl/v850_hw_queue.sv
// Halfword FIFO: push 0/1/2 and pop 0/1/2 per cycle, flush, two-entry head peek.
module v850_hw_queue
    import v850_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int AW     = $clog2(QDEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [1:0]  push_n_i,
    input  hw_t         push_hw0_i,
    input  hw_t         push_hw1_i,
    input  logic [1:0]  pop_n_i,
    output logic [AW:0] count_o,
    output logic [AW:0] free_o,
    output hw_t         head0_o,
    output hw_t         head1_o
);

    hw_t           mem_q [QDEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_n_i);
            rd_q  <= rd_q + AW'(pop_n_i);
            cnt_q <= cnt_q + (AW+1)'(push_n_i) - (AW+1)'(pop_n_i);
        end
    end

    // Storage is not reset; the consumer masks the head whenever count is too low.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (push_n_i != 2'd0) mem_q[wr_q]          <= push_hw0_i;
            if (push_n_i == 2'd2) mem_q[wr_q + AW'(1)] <= push_hw1_i;
        end
    end

    assign count_o = cnt_q;
    assign free_o  = (AW+1)'(QDEPTH) - cnt_q;
    assign head0_o = mem_q[rd_q];
    assign head1_o = mem_q[rd_q + AW'(1)];

endmodule

// File: rtl/v850_fetch_align.sv
// Fetch/align: word fetch with credit-based flow control, halfword queue, 16/32-bit issue.
// Optional V850_FETCH_STATS_EN adds stat_issued / stat_stall counters.
module v850_fetch_align
    import v850_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 8,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_len32
`ifdef V850_FETCH_STATS_EN
   ,output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
`endif
);

    localparam int AW = $clog2(QDEPTH);

    addr_t       fetch_addr_q, fetch_addr_d;
    addr_t       pc_q, pc_d;
    logic        skip_lo_q, skip_lo_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  discard_q, discard_d;

    logic [AW:0] q_count, q_free;
    hw_t         head0, head1, push_hw0;
    logic [1:0]  push_n, pop_n;
    logic        len32, valid, hs, req_ok, accept, rsp;
    logic        unused_bits;

    assign unused_bits = redirect_pc[0];

    v850_hw_queue #(.QDEPTH(QDEPTH)) u_q (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_valid),
        .push_n_i   (push_n),
        .push_hw0_i (push_hw0),
        .push_hw1_i (imem_rdata[31:16]),
        .pop_n_i    (pop_n),
        .count_o    (q_count),
        .free_o     (q_free),
        .head0_o    (head0),
        .head1_o    (head1)
    );

    always_comb begin
        len32  = is_len32(head0);
        valid  = !rst && ((q_count >= (AW+1)'(2)) || (q_count != '0 && !len32));
        hs     = valid && dec_ready;
        // Every in-flight word, plus the one about to be asked for, must fit.
        req_ok = !rst && !redirect_valid && (int'(outst_q) < MAX_OUTST) &&
                 (int'(q_free) >= 2 * (int'(outst_q) + 1));
        accept = req_ok && imem_ready;
        rsp    = imem_rvalid && (outst_q != 2'd0);

        pop_n        = hs ? (len32 ? 2'd2 : 2'd1) : 2'd0;
        push_n       = 2'd0;
        push_hw0     = skip_lo_q ? imem_rdata[31:16] : imem_rdata[15:0];
        outst_d      = outst_q + {1'b0, accept} - {1'b0, rsp};
        fetch_addr_d = fetch_addr_q;
        skip_lo_d    = skip_lo_q;
        discard_d    = discard_q;
        pc_d         = pc_q;

        if (redirect_valid) begin
            discard_d    = outst_q - {1'b0, rsp};
            fetch_addr_d = {redirect_pc[31:2], 2'b00};
            skip_lo_d    = redirect_pc[1];
            pc_d         = {redirect_pc[31:1], 1'b0};
        end else begin
            if (accept) fetch_addr_d = fetch_addr_q + 32'd4;
            if (rsp) begin
                if (discard_q != 2'd0) begin
                    discard_d = discard_q - 2'd1;
                end else begin
                    push_n    = skip_lo_q ? 2'd1 : 2'd2;
                    skip_lo_d = 1'b0;
                end
            end
            if (hs) pc_d = pc_q + (len32 ? 32'd4 : 32'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            skip_lo_q    <= RESET_PC[1];
            pc_q         <= {RESET_PC[31:1], 1'b0};
            outst_q      <= 2'd0;
            discard_q    <= 2'd0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            skip_lo_q    <= skip_lo_d;
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
        end
    end

    assign imem_req  = req_ok;
    assign imem_addr = fetch_addr_q;
    assign dec_valid = valid;
    assign dec_pc    = pc_q;
    assign dec_len32 = valid && len32;
    assign dec_instr = valid ? {(len32 ? head1 : NOP_HW), head0} : {NOP_HW, NOP_HW};

`ifdef V850_FETCH_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= 32'd0;
            stat_stall_q  <= 32'd0;
        end else begin
            if (hs) stat_issued_q <= stat_issued_q + 32'd1;
            if (!valid && !redirect_valid) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

    a_rsp_outst: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> outst_q != 2'd0);

endmodule

// File: tb/tb_v850_fetch_align.sv
// Directed bench for v850_fetch_align: in-order imem model, handshake log, hand-computed expectations.
module tb_v850_fetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready, dec_len32;
    logic [31:0] dec_instr, dec_pc;
`ifdef V850_FETCH_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    always #5 clk = ~clk;

    v850_fetch_align #(.RESET_PC(32'h100), .QDEPTH(8), .MAX_OUTST(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_len32      (dec_len32)
`ifdef V850_FETCH_STATS_EN
       ,.stat_issued    (stat_issued),
        .stat_stall     (stat_stall)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        len;
    } iss_t;

    iss_t        iss_q[$];
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    int          rsp_budget, nrsp, stall_cnt;
    int          n_vec, n_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_def(logic [31:0] a);
        return {7'h00, a[9:1]};
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h07E0_0000;
            32'h0000_0104: return 32'h0001_1234;
            32'h0000_0200: return 32'h0123_4567;
            32'h0000_0300: return 32'h5678_0600;
            default:       return {hw_def(a + 32'd2), hw_def(a)};
        endcase
    endfunction

    function automatic logic [15:0] hw_at(logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ref_instr(logic [31:0] pc);
        logic [15:0] h;
        h = hw_at(pc);
        if (h[10:9] == 2'b11) return {hw_at(pc + 32'd2), h};
        return {16'h0000, h};
    endfunction

    function automatic logic [31:0] iss_pc(int i);
        return (i < iss_q.size()) ? iss_q[i].pc : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] iss_instr(int i);
        return (i < iss_q.size()) ? iss_q[i].instr : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] iss_len(int i);
        return (i < iss_q.size()) ? {31'd0, iss_q[i].len} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] req_at(int i);
        return (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF;
    endfunction

    // imem: in-order, one cycle after accept; also logs requests and handshakes.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) pend.delete();
            if (!rst && rsp_budget > 0 && pend.size() > 0) begin
                imem_rdata  = mem_word(pend.pop_front());
                imem_rvalid = 1'b1;
                rsp_budget--;
                nrsp++;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            #3;
            if (!rst && imem_req && imem_ready) begin
                pend.push_back(imem_addr);
                req_log.push_back(imem_addr);
            end
            if (!rst && dec_valid && dec_ready) iss_q.push_back('{dec_pc, dec_instr, dec_len32});
            if (!rst && !dec_valid && !redirect_valid) stall_cnt++;
        end
    end

    initial begin
        int          k0, r0, n0, bad;
        logic        got;
        logic [31:0] snap_pc, snap_instr, pc_h;

        n_vec = 0; n_miss = 0; nrsp = 0; stall_cnt = 0;
        rst = 1'b1; imem_ready = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        rsp_budget = 1;

        // reset state
        repeat (3) @(negedge clk);
        #4;
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr,          32'd0);
        chk("rst_pc",    dec_pc,             32'h100);
        chk("rst_len",   {31'd0, dec_len32}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("first_req",   {31'd0, imem_req},  32'd1);
        chk("first_addr",  imem_addr,          32'h100);
        chk("first_valid", {31'd0, dec_valid}, 32'd0);

        // only the first word delivered: 32-bit at 0x102 must wait
        repeat (8) @(negedge clk);
        #4;
        chk("straddle_n",     iss_q.size(),       32'd1);
        chk("straddle_valid", {31'd0, dec_valid}, 32'd0);
        chk("straddle_pc",    dec_pc,             32'h102);

        @(negedge clk);
        rsp_budget = 1000000;
        repeat (30) @(negedge clk);
        chk("mix0_pc",  iss_pc(0),    32'h100);
        chk("mix0_len", iss_len(0),   32'd0);
        chk("mix1_pc",  iss_pc(1),    32'h102);
        chk("mix1_ins", iss_instr(1), 32'h1234_07E0);
        chk("mix1_len", iss_len(1),   32'd1);
        chk("mix2_pc",  iss_pc(2),    32'h106);
        chk("mix2_ins", iss_instr(2), 32'h0000_0001);
        chk("mix3_ins", iss_instr(3), 32'h0000_0084);

        // decoder stall: hold outputs, credit limit stops requests
        dec_ready = 1'b0;
        #4;
        snap_pc = dec_pc; snap_instr = dec_instr;
        chk("stall_valid", {31'd0, dec_valid}, 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #4;
            if (dec_pc !== snap_pc || dec_instr !== snap_instr || dec_valid !== 1'b1) bad++;
        end
        chk("stall_stable", bad,                32'd0);
        chk("credit_stop",  {31'd0, imem_req},  32'd0);
        chk("credit_outst", pend.size(),        32'd0);
        n0 = iss_q.size();
        @(negedge clk);
        dec_ready = 1'b1;
        repeat (30) @(negedge clk);
        chk("resume_pc", iss_pc(n0), snap_pc);
        bad = 0;
        for (int i = n0; i + 1 < iss_q.size(); i++)
            if (iss_q[i+1].pc !== iss_q[i].pc + (iss_q[i].len ? 32'd4 : 32'd2)) bad++;
        chk("resume_seq", bad, 32'd0);

        // redirect with two requests in flight
        rsp_budget = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pend.size() == 2) got = 1'b1;
        end
        chk("two_outst", {31'd0, got}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        r0 = req_log.size();
        #4;
        chk("redir_noreq", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        k0 = iss_q.size();
        rsp_budget = 1000000;
        repeat (15) @(negedge clk);
        chk("redir_addr",  req_at(r0),        32'h200);
        chk("redir_pc0",   iss_pc(k0),        32'h202);
        chk("redir_ins0",  iss_instr(k0),     32'h0000_0123);
        chk("redir_pc1",   iss_pc(k0 + 1),    32'h204);
        chk("redir_ins1",  iss_instr(k0 + 1), 32'h0000_0102);

        // redirect colliding with a handshake and an arriving word
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #2;
            if (imem_rvalid && dec_valid) got = 1'b1;
        end
        redirect_valid = got; redirect_pc = 32'h300;
        k0 = iss_q.size();
        pc_h = dec_pc;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("coll_found", {31'd0, got},    32'd1);
        chk("coll_once",  iss_q.size(),    k0 + 1);
        chk("coll_pc",    iss_pc(k0),      pc_h);
        #4;
        chk("coll_novalid", {31'd0, dec_valid}, 32'd0);
        repeat (15) @(negedge clk);
        chk("coll_new_pc",  iss_pc(k0 + 1),    32'h300);
        chk("coll_new_ins", iss_instr(k0 + 1), 32'h5678_0600);
        chk("coll_new_len", iss_len(k0 + 1),   32'd1);
        chk("coll_nxt_pc",  iss_pc(k0 + 2),    32'h304);
        chk("coll_nxt_ins", iss_instr(k0 + 2), 32'h0000_0182);

        // address wrap
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        r0 = req_log.size();
        @(negedge clk);
        redirect_valid = 1'b0;
        k0 = iss_q.size();
        repeat (15) @(negedge clk);
        chk("wrap_req0", req_at(r0),        32'hFFFF_FFFC);
        chk("wrap_req1", req_at(r0 + 1),    32'h0000_0000);
        chk("wrap_pc0",  iss_pc(k0),        32'hFFFF_FFFC);
        chk("wrap_ins0", iss_instr(k0),     32'h0000_01FE);
        chk("wrap_pc1",  iss_pc(k0 + 1),    32'hFFFF_FFFE);
        chk("wrap_ins1", iss_instr(k0 + 1), 32'h0000_01FF);
        chk("wrap_pc2",  iss_pc(k0 + 2),    32'h0000_0000);

`ifdef V850_FETCH_STATS_EN
        chk("stat_issued", stat_issued, iss_q.size());
        chk("stat_stall",  stat_stall,  stall_cnt);
`endif

        // every issued instruction matches memory at its pc
        for (int i = 0; i < iss_q.size(); i++) begin
            chk("content_ins", iss_q[i].instr, ref_instr(iss_q[i].pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
